// File: rtl/axi4_lite_master_bridge_pkg.sv
// Shared state encoding and AXI response codes for the core-to-AXI4-Lite bridge.
// Pure declarations; no latency or backpressure of its own.
package bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

endpackage

// File: rtl/axi4_lite_master_bridge_if.sv
// AXI4-Lite bus between the bridge (master) and peripheral slaves; 1-bit resp, no prot.
// Wires only: handshakes are plain valid/ready, no added latency.
interface axi4_lite_master_bridge_if;

  logic [31:0] m_axi_araddr_o;
  logic        m_axi_arvalid_o;
  logic        m_axi_arready_i;
  logic [31:0] m_axi_rdata_i;
  logic        m_axi_rresp_i;
  logic        m_axi_rvalid_i;
  logic        m_axi_rready_o;
  logic [31:0] m_axi_awaddr_o;
  logic        m_axi_awvalid_o;
  logic        m_axi_awready_i;
  logic [31:0] m_axi_wdata_o;
  logic [3:0]  m_axi_wstrb_o;
  logic        m_axi_wvalid_o;
  logic        m_axi_wready_i;
  logic        m_axi_bresp_i;
  logic        m_axi_bvalid_i;
  logic        m_axi_bready_o;

  modport master (
    output m_axi_araddr_o, m_axi_arvalid_o, m_axi_rready_o,
    output m_axi_awaddr_o, m_axi_awvalid_o, m_axi_wdata_o, m_axi_wstrb_o, m_axi_wvalid_o,
    output m_axi_bready_o,
    input  m_axi_arready_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rvalid_i,
    input  m_axi_awready_i, m_axi_wready_i, m_axi_bresp_i, m_axi_bvalid_i
  );

  modport slave (
    input  m_axi_araddr_o, m_axi_arvalid_o, m_axi_rready_o,
    input  m_axi_awaddr_o, m_axi_awvalid_o, m_axi_wdata_o, m_axi_wstrb_o, m_axi_wvalid_o,
    input  m_axi_bready_o,
    output m_axi_arready_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rvalid_i,
    output m_axi_awready_i, m_axi_wready_i, m_axi_bresp_i, m_axi_bvalid_i
  );

endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding core load/store to AXI4-Lite master; zero-wait completion pulse 2 edges after accept.
// req_ready_o only in IDLE; slave stalls bounded by TIMEOUT_CYCLES (0 = wait forever), then error completion.
module axi4_lite_master_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [31:0]                       req_addr_i,
  input  logic [31:0]                       req_wdata_i,
  input  logic [3:0]                        req_wstrb_i,
  input  logic [3:0]                        req_size_i,
  output logic                              resp_valid_o,
  output logic [31:0]                       resp_rdata_o,
  output logic                              resp_err_o,
  axi4_lite_master_bridge_if.master         m_axi,
  output logic [3:0]                        read_size_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);

  state_t          r_state;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [3:0]      r_size;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_aw_done;
  logic            r_w_done;
  logic [CW-1:0]   r_cnt;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic            r_arvalid;
  logic            r_rready;
  logic            r_awvalid;
  logic            r_wvalid;
  logic            r_bready;

  logic [CW-1:0]   w_cnt_inc;
  logic            w_timeout;
  logic            w_aw_done;
  logic            w_w_done;

  // Timeout fires on the edge that completes the TIMEOUT_CYCLES-th wait cycle.
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TO_CNT);
  assign w_aw_done = r_aw_done | (r_awvalid & m_axi.m_axi_awready_i);
  assign w_w_done  = r_w_done  | (r_wvalid  & m_axi.m_axi_wready_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_size       <= '0;
      r_rdata      <= '0;
      r_err        <= RESP_OKAY;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_addr      <= req_addr_i;
            r_wdata     <= req_wdata_i;
            r_wstrb     <= req_wstrb_i;
            r_size      <= req_size_i;
            r_cnt       <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_req_ready <= 1'b0;
            if (req_wstrb_i == 4'h0) begin
              r_state   <= RD_ADDR;
              r_arvalid <= 1'b1;
            end else begin
              r_state   <= WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          r_cnt <= w_cnt_inc;
          if (m_axi.m_axi_arready_i) begin
            r_state   <= RD_DATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end else if (w_timeout) begin
            r_state      <= RESP;
            r_arvalid    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= RESP_ERR;
            r_rdata      <= '0;
          end
        end
        RD_DATA: begin
          r_cnt <= w_cnt_inc;
          if (m_axi.m_axi_rvalid_i) begin
            r_state      <= RESP;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= m_axi.m_axi_rresp_i;
            r_rdata      <= m_axi.m_axi_rdata_i;
          end else if (w_timeout) begin
            r_state      <= RESP;
            r_rready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= RESP_ERR;
            r_rdata      <= '0;
          end
        end
        WR: begin
          r_cnt <= w_cnt_inc;
          if (w_aw_done && w_w_done) begin
            r_state   <= WR_RESP;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
          end else if (w_timeout) begin
            r_state      <= RESP;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= RESP_ERR;
            r_rdata      <= '0;
          end else begin
            r_aw_done <= w_aw_done;
            r_w_done  <= w_w_done;
            r_awvalid <= ~w_aw_done;
            r_wvalid  <= ~w_w_done;
          end
        end
        WR_RESP: begin
          r_cnt <= w_cnt_inc;
          if (m_axi.m_axi_bvalid_i) begin
            r_state      <= RESP;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= m_axi.m_axi_bresp_i;
            r_rdata      <= '0;
          end else if (w_timeout) begin
            r_state      <= RESP;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_err        <= RESP_ERR;
            r_rdata      <= '0;
          end
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_err        <= RESP_OKAY;
          r_rdata      <= '0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o            = r_req_ready;
  assign resp_valid_o           = r_resp_valid;
  assign resp_rdata_o           = r_rdata;
  assign resp_err_o             = r_err;
  assign read_size_o            = r_size;
  assign m_axi.m_axi_araddr_o   = r_addr;
  assign m_axi.m_axi_arvalid_o  = r_arvalid;
  assign m_axi.m_axi_rready_o   = r_rready;
  assign m_axi.m_axi_awaddr_o   = r_addr;
  assign m_axi.m_axi_awvalid_o  = r_awvalid;
  assign m_axi.m_axi_wdata_o    = r_wdata;
  assign m_axi.m_axi_wstrb_o    = r_wstrb;
  assign m_axi.m_axi_wvalid_o   = r_wvalid;
  assign m_axi.m_axi_bready_o   = r_bready;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench for axi4_lite_master_bridge: scripted slave, hand-computed expectations.
module tb_axi4_lite_master_bridge;
  import bridge_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic [3:0]  req_size_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [3:0]  read_size_o;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int bhs_cnt  = 0;
  int resp_cnt = 0;

  axi4_lite_master_bridge_if u_axi ();

  axi4_lite_master_bridge #(.TIMEOUT_CYCLES(8)) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_wstrb_i  (req_wstrb_i),
    .req_size_i   (req_size_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .m_axi        (u_axi.master),
    .read_size_o  (read_size_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!rst_i && req_valid_i && req_ready_o) acc_cnt++;
    if (u_axi.m_axi_bvalid_i && u_axi.m_axi_bready_o) bhs_cnt++;
    if (resp_valid_o) resp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    u_axi.m_axi_arready_i = 1'b0;
    u_axi.m_axi_rdata_i   = 32'h0;
    u_axi.m_axi_rresp_i   = RESP_OKAY;
    u_axi.m_axi_rvalid_i  = 1'b0;
    u_axi.m_axi_awready_i = 1'b0;
    u_axi.m_axi_wready_i  = 1'b0;
    u_axi.m_axi_bresp_i   = RESP_OKAY;
    u_axi.m_axi_bvalid_i  = 1'b0;
  endtask

  // Presents one request in IDLE and returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [3:0] size);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = wstrb;
    req_size_i  = size;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  initial begin
    int lat;
    int a0;
    int b0;
    int r0;

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = 32'h0;
    req_wdata_i = 32'h0;
    req_wstrb_i = 4'h0;
    req_size_i  = 4'h0;
    slave_idle();
    repeat (2) @(negedge clk_i);
    check("rst_req_ready",  32'(req_ready_o), 32'd1);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_resp_err",   32'(resp_err_o), 32'd0);
    check("rst_resp_rdata", resp_rdata_o, 32'h0);
    check("rst_valids", 32'({u_axi.m_axi_arvalid_o, u_axi.m_axi_awvalid_o, u_axi.m_axi_wvalid_o}), 32'd0);
    check("rst_readies", 32'({u_axi.m_axi_rready_o, u_axi.m_axi_bready_o}), 32'd0);
    check("rst_addr", u_axi.m_axi_araddr_o, 32'h0);
    check("rst_size", 32'(read_size_o), 32'd0);
    rst_i = 1'b0;

    // Stray responses while idle must not be acknowledged.
    @(negedge clk_i);
    u_axi.m_axi_rvalid_i = 1'b1;
    u_axi.m_axi_bvalid_i = 1'b1;
    @(negedge clk_i);
    check("idle_rready", 32'(u_axi.m_axi_rready_o), 32'd0);
    check("idle_bready", 32'(u_axi.m_axi_bready_o), 32'd0);
    check("idle_no_resp", 32'(resp_valid_o), 32'd0);
    slave_idle();

    // Zero-wait read.
    u_axi.m_axi_arready_i = 1'b1;
    u_axi.m_axi_rvalid_i  = 1'b1;
    u_axi.m_axi_rdata_i   = 32'hDEAD_BEEF;
    issue(32'h2000_0004, 32'h0, 4'h0, 4'h2);
    check("rd_arvalid", 32'(u_axi.m_axi_arvalid_o), 32'd1);
    check("rd_araddr", u_axi.m_axi_araddr_o, 32'h2000_0004);
    check("rd_size_e0", 32'(read_size_o), 32'd2);
    check("rd_busy", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    check("rd_rready", 32'(u_axi.m_axi_rready_o), 32'd1);
    check("rd_arvalid_drop", 32'(u_axi.m_axi_arvalid_o), 32'd0);
    check("rd_size_e1", 32'(read_size_o), 32'd2);
    check("rd_no_early_resp", 32'(resp_valid_o), 32'd0);
    @(negedge clk_i);
    check("rd_resp_valid", 32'(resp_valid_o), 32'd1);
    check("rd_rdata", resp_rdata_o, 32'hDEAD_BEEF);
    check("rd_err", 32'(resp_err_o), 32'd0);
    check("rd_size_e2", 32'(read_size_o), 32'd2);
    check("rd_araddr_held", u_axi.m_axi_araddr_o, 32'h2000_0004);
    @(negedge clk_i);
    check("rd_resp_pulse", 32'(resp_valid_o), 32'd0);
    check("rd_ready_again", 32'(req_ready_o), 32'd1);
    slave_idle();

    // Write with AW accepted two cycles before W.
    issue(32'h2000_0008, 32'h0000_00FF, 4'hF, 4'h0);
    check("wr_awvalid", 32'(u_axi.m_axi_awvalid_o), 32'd1);
    check("wr_wvalid", 32'(u_axi.m_axi_wvalid_o), 32'd1);
    check("wr_awaddr", u_axi.m_axi_awaddr_o, 32'h2000_0008);
    check("wr_wdata", u_axi.m_axi_wdata_o, 32'h0000_00FF);
    check("wr_wstrb", 32'(u_axi.m_axi_wstrb_o), 32'hF);
    u_axi.m_axi_awready_i = 1'b1;
    @(negedge clk_i);
    check("wr_aw_drop", 32'(u_axi.m_axi_awvalid_o), 32'd0);
    check("wr_w_hold1", 32'(u_axi.m_axi_wvalid_o), 32'd1);
    u_axi.m_axi_awready_i = 1'b0;
    @(negedge clk_i);
    check("wr_w_hold2", 32'(u_axi.m_axi_wvalid_o), 32'd1);
    check("wr_no_bready", 32'(u_axi.m_axi_bready_o), 32'd0);
    u_axi.m_axi_wready_i = 1'b1;
    @(negedge clk_i);
    check("wr_w_drop", 32'(u_axi.m_axi_wvalid_o), 32'd0);
    check("wr_bready", 32'(u_axi.m_axi_bready_o), 32'd1);
    u_axi.m_axi_wready_i = 1'b0;
    u_axi.m_axi_bvalid_i = 1'b1;
    b0 = bhs_cnt;
    @(negedge clk_i);
    check("wr_resp_valid", 32'(resp_valid_o), 32'd1);
    check("wr_err", 32'(resp_err_o), 32'd0);
    check("wr_rdata", resp_rdata_o, 32'h0);
    check("wr_bready_drop", 32'(u_axi.m_axi_bready_o), 32'd0);
    u_axi.m_axi_bvalid_i = 1'b0;
    @(negedge clk_i);
    check("wr_b_count", bhs_cnt - b0, 32'd1);

    // Zero-wait write with error response: completes in 3 edges.
    u_axi.m_axi_awready_i = 1'b1;
    u_axi.m_axi_wready_i  = 1'b1;
    u_axi.m_axi_bvalid_i  = 1'b1;
    u_axi.m_axi_bresp_i   = RESP_ERR;
    issue(32'h2000_0010, 32'hA5A5_A5A5, 4'h3, 4'h0);
    @(negedge clk_i);
    check("wrerr_bready", 32'(u_axi.m_axi_bready_o), 32'd1);
    @(negedge clk_i);
    check("wrerr_resp_valid", 32'(resp_valid_o), 32'd1);
    check("wrerr_err", 32'(resp_err_o), 32'(RESP_ERR));
    check("wrerr_rdata", resp_rdata_o, 32'h0);
    slave_idle();
    @(negedge clk_i);

    // Read with error response keeps slave data.
    u_axi.m_axi_arready_i = 1'b1;
    u_axi.m_axi_rvalid_i  = 1'b1;
    u_axi.m_axi_rdata_i   = 32'h1234_5678;
    u_axi.m_axi_rresp_i   = RESP_ERR;
    issue(32'h2000_0014, 32'h0, 4'h0, 4'h1);
    @(negedge clk_i);
    @(negedge clk_i);
    check("rderr_resp_valid", 32'(resp_valid_o), 32'd1);
    check("rderr_err", 32'(resp_err_o), 32'(RESP_ERR));
    check("rderr_rdata", resp_rdata_o, 32'h1234_5678);
    slave_idle();
    @(negedge clk_i);

    // Timeout with arready stuck low.
    issue(32'h2000_0020, 32'h0, 4'h0, 4'h2);
    check("to_arvalid", 32'(u_axi.m_axi_arvalid_o), 32'd1);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        lat = k;
        break;
      end
    end
    check("to_latency", lat, 32'd8);
    check("to_arvalid_drop", 32'(u_axi.m_axi_arvalid_o), 32'd0);
    check("to_err", 32'(resp_err_o), 32'd1);
    check("to_rdata", resp_rdata_o, 32'h0);
    @(negedge clk_i);
    check("to_ready_next", 32'(req_ready_o), 32'd1);

    // Back-to-back requests with req_valid held high.
    u_axi.m_axi_arready_i = 1'b1;
    u_axi.m_axi_rvalid_i  = 1'b1;
    u_axi.m_axi_rdata_i   = 32'hCAFE_0001;
    u_axi.m_axi_awready_i = 1'b1;
    u_axi.m_axi_wready_i  = 1'b1;
    u_axi.m_axi_bvalid_i  = 1'b1;
    a0 = acc_cnt;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h2000_0030;
    req_wstrb_i = 4'h0;
    req_size_i  = 4'h2;
    @(negedge clk_i);
    check("b2b_busy_e0", 32'(req_ready_o), 32'd0);
    req_addr_i  = 32'h2000_0034;
    req_wdata_i = 32'h0000_0011;
    req_wstrb_i = 4'h1;
    @(negedge clk_i);
    check("b2b_busy_e1", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    check("b2b_resp1", 32'(resp_valid_o), 32'd1);
    check("b2b_rdata1", resp_rdata_o, 32'hCAFE_0001);
    check("b2b_busy_e2", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    check("b2b_idle_ready", 32'(req_ready_o), 32'd1);
    check("b2b_one_accept", acc_cnt - a0, 32'd1);
    @(negedge clk_i);
    check("b2b_two_accept", acc_cnt - a0, 32'd2);
    check("b2b_awvalid", 32'(u_axi.m_axi_awvalid_o), 32'd1);
    check("b2b_awaddr", u_axi.m_axi_awaddr_o, 32'h2000_0034);
    req_valid_i = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        lat = k;
        break;
      end
    end
    check("b2b_resp2_lat", lat, 32'd2);
    check("b2b_err2", 32'(resp_err_o), 32'd0);
    slave_idle();
    @(negedge clk_i);

    // Reset while waiting in RD_DATA.
    u_axi.m_axi_arready_i = 1'b1;
    issue(32'h2000_0040, 32'h0, 4'h0, 4'h2);
    @(negedge clk_i);
    check("rst_mid_rready", 32'(u_axi.m_axi_rready_o), 32'd1);
    rst_i = 1'b1;
    r0 = resp_cnt;
    @(negedge clk_i);
    check("rst_mid_arvalid", 32'(u_axi.m_axi_arvalid_o), 32'd0);
    check("rst_mid_rready0", 32'(u_axi.m_axi_rready_o), 32'd0);
    check("rst_mid_resp", 32'(resp_valid_o), 32'd0);
    check("rst_mid_ready", 32'(req_ready_o), 32'd1);
    rst_i = 1'b0;
    u_axi.m_axi_rvalid_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_mid_no_resp", resp_cnt - r0, 32'd0);
    check("rst_mid_late_r", 32'(u_axi.m_axi_rready_o), 32'd0);
    slave_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
